// File: rtl/sd_spi_card_if.sv
// SPI bus between an SD host and the card model: host drives clock, select and MOSI.
interface sd_spi_card_if;
  logic spi_clk;
  logic spi_cs;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_clk, output spi_cs, output spi_mosi, input spi_miso);
  modport slave  (input spi_clk, input spi_cs, input spi_mosi, output spi_miso);
endinterface

// File: rtl/sd_spi_card.sv
// SD card SPI-mode model with NBLOCKS x 512-byte block storage (CMD0/8/55/41/58/17/24).
// Optional feature macro SDCARD_CRC_EN: CRC7 check on CMD0/CMD8 and CRC16 on read data.
module sd_spi_card #(
  parameter int NBLOCKS       = 4,
  parameter int ACMD41_BUSY   = 2,
  parameter int WR_BUSY_BYTES = 4
) (
  input  logic             clk,
  input  logic             reset,
  sd_spi_card_if.slave     spi,
  output logic             in_idle,
  output logic             busy,
  output logic [5:0]       last_cmd
);
  localparam int BW    = (NBLOCKS > 1) ? $clog2(NBLOCKS) : 1;
  localparam int AW    = BW + 9;
  localparam int DEPTH = NBLOCKS * 512;

  typedef enum logic [3:0] {
    CMD_WAIT, CMD_RX, NCR, RESP, RD_GAP, RD_TOKEN, RD_DATA, RD_CRC,
    WR_TOKEN, WR_DATA, WR_CRC, WR_DRESP, WR_BUSY
  } state_e;

  logic [2:0]    sclk_q;
  logic [1:0]    cs_q;
  logic [1:0]    mosi_q;
  logic [2:0]    bit_cnt_q;
  logic [6:0]    rx_q;
  logic [7:0]    tx_q, tx_d;
  logic          miso_q;
  state_e        state_q, state_d, after_q, after_d;
  logic [9:0]    cnt_q, cnt_d;
  logic [5:0]    cmd_q, cmd_d, last_cmd_q, last_cmd_d;
  logic [31:0]   arg_q, arg_d;
  logic [39:0]   resp_q, resp_d;
  logic [2:0]    resp_last_q, resp_last_d;
  logic [BW-1:0] blk_q, blk_d;
  logic [8:0]    rd_ptr_q, rd_ptr_d;
  logic          acmd_q, acmd_d, in_idle_q, in_idle_d, busy_q, busy_d;
  logic [7:0]    acnt_q, acnt_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    rdata_q;
  logic [AW-1:0] ram_addr_s;
  logic          we_s, rise_s, fall_s, cs_hi_s, byte_done_s, crc_ok_s;
  logic [7:0]    rx_byte_s;
  logic [15:0]   crc_out_s;

  // index [1] is the synchronized level, sclk_q[2] its previous value for edge detection
  assign rise_s      = sclk_q[1] & ~sclk_q[2];
  assign fall_s      = ~sclk_q[1] & sclk_q[2];
  assign cs_hi_s     = cs_q[1];
  assign rx_byte_s   = {rx_q, mosi_q[1]};
  assign byte_done_s = ~cs_hi_s & rise_s & (bit_cnt_q == 3'd7);
  assign ram_addr_s  = we_s ? {blk_q, cnt_q[8:0]} : {blk_q, rd_ptr_q};
  assign spi.spi_miso = miso_q;
  assign in_idle     = in_idle_q;
  assign busy        = busy_q;
  assign last_cmd    = last_cmd_q;

`ifdef SDCARD_CRC_EN
  logic [15:0] crc_q, crc_d;

  function automatic logic [6:0] crc7_40(input logic [39:0] d);
    logic [6:0] c;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      c = {c[5:0], 1'b0} ^ ((d[i] ^ c[6]) ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      c = {c[14:0], 1'b0} ^ ((d[i] ^ c[15]) ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  assign crc_ok_s  = (rx_byte_s == {crc7_40({2'b01, cmd_q, arg_q}), 1'b1});
  assign crc_out_s = crc_q;

  // running CRC16 over each data byte as it is loaded for transmission
  always_comb begin
    crc_d = crc_q;
    if (byte_done_s && state_q == RD_TOKEN) begin
      crc_d = crc16_byte(16'h0000, rdata_q);
    end else if (byte_done_s && state_q == RD_DATA && cnt_q != 10'd511) begin
      crc_d = crc16_byte(crc_q, rdata_q);
    end else begin
      crc_d = crc_q;
    end
  end

  // CRC16 register
  always_ff @(posedge clk) begin
    if (reset) crc_q <= 16'h0000;
    else       crc_q <= crc_d;
  end
`else
  assign crc_ok_s  = 1'b1;
  assign crc_out_s = 16'hFFFF;
`endif

  // two-flop synchronizers for the host SPI lines
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_q <= 3'b000;
      cs_q   <= 2'b11;
      mosi_q <= 2'b11;
    end else begin
      sclk_q <= {sclk_q[1:0], spi.spi_clk};
      cs_q   <= {cs_q[0], spi.spi_cs};
      mosi_q <= {mosi_q[0], spi.spi_mosi};
    end
  end

  // bit engine: next byte's MSB goes out the moment a byte completes, later bits on falling edges
  always_ff @(posedge clk) begin
    if (reset || cs_hi_s) begin
      bit_cnt_q <= 3'd0;
      rx_q      <= 7'h7F;
      tx_q      <= 8'hFF;
      miso_q    <= 1'b1;
    end else if (rise_s) begin
      rx_q      <= rx_byte_s[6:0];
      bit_cnt_q <= bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        tx_q   <= tx_d;
        miso_q <= tx_d[7];
      end
    end else if (fall_s && bit_cnt_q != 3'd0) begin
      miso_q <= tx_q[3'd7 - bit_cnt_q];
    end
  end

  // block storage: single port, registered read of the current read pointer
  always_ff @(posedge clk) begin
    if (we_s && !reset) mem_q[ram_addr_s] <= rx_byte_s;
    rdata_q <= mem_q[ram_addr_s];
  end

  // protocol state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CMD_WAIT;
      after_q     <= CMD_WAIT;
      cnt_q       <= 10'd0;
      cmd_q       <= 6'd0;
      last_cmd_q  <= 6'd0;
      arg_q       <= 32'd0;
      resp_q      <= 40'hFF_FFFF_FFFF;
      resp_last_q <= 3'd0;
      blk_q       <= '0;
      rd_ptr_q    <= 9'd0;
      acmd_q      <= 1'b0;
      acnt_q      <= 8'd0;
      in_idle_q   <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      after_q     <= after_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      last_cmd_q  <= last_cmd_d;
      arg_q       <= arg_d;
      resp_q      <= resp_d;
      resp_last_q <= resp_last_d;
      blk_q       <= blk_d;
      rd_ptr_q    <= rd_ptr_d;
      acmd_q      <= acmd_d;
      acnt_q      <= acnt_d;
      in_idle_q   <= in_idle_d;
      busy_q      <= busy_d;
    end
  end

  // next-state: everything advances once per completed byte; tx_d is the byte sent in state_d
  always_comb begin
    state_d = state_q;  after_d = after_q;  cnt_d = cnt_q;  cmd_d = cmd_q;
    last_cmd_d = last_cmd_q;  arg_d = arg_q;  resp_d = resp_q;  resp_last_d = resp_last_q;
    blk_d = blk_q;  rd_ptr_d = rd_ptr_q;  acmd_d = acmd_q;  acnt_d = acnt_q;
    in_idle_d = in_idle_q;  busy_d = busy_q;  tx_d = 8'hFF;  we_s = 1'b0;
    if (cs_hi_s) begin
      state_d = CMD_WAIT;
      cnt_d   = 10'd0;
      busy_d  = 1'b0;
    end else if (byte_done_s) begin
      case (state_q)
        CMD_WAIT: begin
          if (rx_byte_s[7:6] == 2'b01) begin
            state_d = CMD_RX;
            cmd_d   = rx_byte_s[5:0];
            cnt_d   = 10'd0;
          end else begin
            state_d = CMD_WAIT;
          end
        end
        CMD_RX: begin
          if (cnt_q != 10'd4) begin
            arg_d = {arg_q[23:0], rx_byte_s};
            cnt_d = cnt_q + 10'd1;
          end else begin
            last_cmd_d  = cmd_q;
            cnt_d       = 10'd0;
            state_d     = NCR;
            acmd_d      = 1'b0;
            after_d     = CMD_WAIT;
            resp_last_d = 3'd0;
            resp_d      = {5'b00000, 1'b1, 1'b0, in_idle_q, 32'hFFFF_FFFF};
            if (acmd_q && cmd_q == 6'd41) begin
              if (acnt_q < 8'(ACMD41_BUSY)) begin
                acnt_d = acnt_q + 8'd1;
                resp_d[39:32] = 8'h01;
              end else begin
                in_idle_d = 1'b0;
                resp_d[39:32] = 8'h00;
              end
            end else begin
              case (cmd_q)
                6'd0: begin
                  if (crc_ok_s) begin
                    in_idle_d = 1'b1;
                    acnt_d    = 8'd0;
                    resp_d[39:32] = 8'h01;
                  end else begin
                    resp_d[39:32] = {4'b0000, 1'b1, 2'b00, in_idle_q};
                  end
                end
                6'd8: begin
                  if (crc_ok_s) begin
                    resp_d      = {7'd0, in_idle_q, 16'h0000, 4'h0, arg_q[11:0]};
                    resp_last_d = 3'd4;
                  end else begin
                    resp_d[39:32] = {4'b0000, 1'b1, 2'b00, in_idle_q};
                  end
                end
                6'd55: begin
                  acmd_d = 1'b1;
                  resp_d[39:32] = {7'd0, in_idle_q};
                end
                6'd58: begin
                  resp_d      = {7'd0, in_idle_q, 32'hC0FF_8000};
                  resp_last_d = 3'd4;
                end
                6'd17, 6'd24: begin
                  if (in_idle_q) begin
                    resp_d[39:32] = 8'h05;
                  end else if (arg_q >= 32'(NBLOCKS)) begin
                    resp_d[39:32] = 8'h40;
                  end else begin
                    resp_d[39:32] = 8'h00;
                    blk_d    = arg_q[BW-1:0];
                    rd_ptr_d = 9'd0;
                    busy_d   = 1'b1;
                    after_d  = (cmd_q == 6'd17) ? RD_GAP : WR_TOKEN;
                  end
                end
                default: resp_d[39:32] = {5'b00000, 1'b1, 1'b0, in_idle_q};
              endcase
            end
          end
        end
        NCR: begin
          state_d = RESP;
          cnt_d   = 10'd0;
          tx_d    = resp_q[39:32];
          resp_d  = {resp_q[31:0], 8'hFF};
        end
        RESP: begin
          if (cnt_q[2:0] == resp_last_q) begin
            state_d = after_q;
            cnt_d   = 10'd0;
          end else begin
            tx_d   = resp_q[39:32];
            resp_d = {resp_q[31:0], 8'hFF};
            cnt_d  = cnt_q + 10'd1;
          end
        end
        RD_GAP: begin
          state_d = RD_TOKEN;
          tx_d    = 8'hFE;
        end
        RD_TOKEN: begin
          state_d  = RD_DATA;
          cnt_d    = 10'd0;
          tx_d     = rdata_q;
          rd_ptr_d = rd_ptr_q + 9'd1;
        end
        RD_DATA: begin
          if (cnt_q == 10'd511) begin
            state_d = RD_CRC;
            cnt_d   = 10'd0;
            tx_d    = crc_out_s[15:8];
          end else begin
            tx_d     = rdata_q;
            rd_ptr_d = rd_ptr_q + 9'd1;
            cnt_d    = cnt_q + 10'd1;
          end
        end
        RD_CRC: begin
          if (cnt_q == 10'd0) begin
            cnt_d = 10'd1;
            tx_d  = crc_out_s[7:0];
          end else begin
            state_d = CMD_WAIT;
          end
        end
        WR_TOKEN: begin
          if (rx_byte_s == 8'hFE) begin
            state_d = WR_DATA;
            cnt_d   = 10'd0;
          end else if (rx_byte_s == 8'hFF) begin
            state_d = WR_TOKEN;
          end else begin
            state_d = CMD_WAIT;
          end
        end
        WR_DATA: begin
          we_s = 1'b1;
          if (cnt_q == 10'd511) begin
            state_d = WR_CRC;
            cnt_d   = 10'd0;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
        WR_CRC: begin
          if (cnt_q == 10'd0) begin
            cnt_d = 10'd1;
          end else begin
            state_d = WR_DRESP;
            tx_d    = 8'h05;
          end
        end
        WR_DRESP: begin
          cnt_d = 10'd0;
          if (WR_BUSY_BYTES == 0) begin
            state_d = CMD_WAIT;
          end else begin
            state_d = WR_BUSY;
            tx_d    = 8'h00;
          end
        end
        WR_BUSY: begin
          if (cnt_q == 10'(WR_BUSY_BYTES - 1)) begin
            state_d = CMD_WAIT;
          end else begin
            cnt_d = cnt_q + 10'd1;
            tx_d  = 8'h00;
          end
        end
        default: state_d = CMD_WAIT;
      endcase
      if (state_d == CMD_WAIT) busy_d = 1'b0;
      else                     busy_d = busy_d;
    end else begin
      state_d = state_q;
    end
  end
endmodule

// File: tb/tb_sd_spi_card.sv
// Directed bench for sd_spi_card acting as an SPI mode-0 host (5 system clocks per SPI bit).
module tb_sd_spi_card;
  logic       clk = 1'b0;
  logic       reset;
  logic       in_idle, busy;
  logic [5:0] last_cmd;
  int         tests = 0;
  int         fails = 0;

  sd_spi_card_if spi_if ();

  sd_spi_card #(.NBLOCKS(4), .ACMD41_BUSY(2), .WR_BUSY_BYTES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .spi      (spi_if.slave),
    .in_idle  (in_idle),
    .busy     (busy),
    .last_cmd (last_cmd)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one byte, MSB first; MISO sampled just before each rising edge
  task automatic xfer(input logic [7:0] b, output logic [7:0] r);
    for (int i = 7; i >= 0; i--) begin
      spi_if.spi_mosi = b[i];
      repeat (3) @(negedge clk);
      r[i] = spi_if.spi_miso;
      spi_if.spi_clk = 1'b1;
      repeat (2) @(negedge clk);
      spi_if.spi_clk = 1'b0;
    end
  endtask

  task automatic xchk(input string tag, input logic [7:0] b, input logic [7:0] exp);
    logic [7:0] r;
    xfer(b, r);
    check(tag, {24'd0, r}, {24'd0, exp});
  endtask

  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
    logic [7:0] r;
    xfer({2'b01, idx}, r);
    xfer(arg[31:24], r);
    xfer(arg[23:16], r);
    xfer(arg[15:8], r);
    xfer(arg[7:0], r);
    xfer(crc, r);
    xchk("ncr", 8'hFF, 8'hFF);
    check("last_cmd", {26'd0, last_cmd}, {26'd0, idx});
  endtask

  task automatic cs_set(input logic v);
    repeat (2) @(negedge clk);
    spi_if.spi_cs = v;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    spi_if.spi_clk  = 1'b0;
    spi_if.spi_cs   = 1'b1;
    spi_if.spi_mosi = 1'b1;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_idle", {31'd0, in_idle}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_last_cmd", {26'd0, last_cmd}, 32'd0);
    check("rst_miso", {31'd0, spi_if.spi_miso}, 32'd1);

    cs_set(1'b0);
    send_cmd(6'd0, 32'h0000_0000, 8'h95);
    xchk("cmd0_r1", 8'hFF, 8'h01);
    check("cmd0_idle", {31'd0, in_idle}, 32'd1);

    send_cmd(6'd17, 32'h0000_0000, 8'hFF);
    xchk("cmd17_idle_r1", 8'hFF, 8'h05);
    xchk("cmd17_idle_nodata", 8'hFF, 8'hFF);

    send_cmd(6'd8, 32'h0000_01AA, 8'h87);
    xchk("r7_0", 8'hFF, 8'h01);
    xchk("r7_1", 8'hFF, 8'h00);
    xchk("r7_2", 8'hFF, 8'h00);
    xchk("r7_3", 8'hFF, 8'h01);
    xchk("r7_4", 8'hFF, 8'hAA);

    for (int k = 0; k < 3; k++) begin
      send_cmd(6'd55, 32'h0000_0000, 8'hFF);
      xchk("cmd55_r1", 8'hFF, 8'h01);
      send_cmd(6'd41, 32'h4000_0000, 8'hFF);
      xchk("acmd41_r1", 8'hFF, (k < 2) ? 8'h01 : 8'h00);
    end
    check("init_idle", {31'd0, in_idle}, 32'd0);

    send_cmd(6'd58, 32'h0000_0000, 8'hFF);
    xchk("ocr_r1", 8'hFF, 8'h00);
    xchk("ocr_0", 8'hFF, 8'hC0);
    xchk("ocr_1", 8'hFF, 8'hFF);
    xchk("ocr_2", 8'hFF, 8'h80);
    xchk("ocr_3", 8'hFF, 8'h00);

    send_cmd(6'd24, 32'h0000_0001, 8'hFF);
    xchk("cmd24_r1", 8'hFF, 8'h00);
    check("cmd24_busy", {31'd0, busy}, 32'd1);
    xchk("wr_token", 8'hFE, 8'hFF);
    for (int i = 0; i < 512; i++) xchk("wr_data", 8'(i), 8'hFF);
    xchk("wr_crc0", 8'hFF, 8'hFF);
    xchk("wr_crc1", 8'hFF, 8'hFF);
    xchk("wr_dresp", 8'hFF, 8'h05);
    for (int i = 0; i < 4; i++) xchk("wr_busy", 8'hFF, 8'h00);
    xchk("wr_end", 8'hFF, 8'hFF);
    check("wr_busy_clr", {31'd0, busy}, 32'd0);

    send_cmd(6'd17, 32'h0000_0001, 8'hFF);
    xchk("rd_r1", 8'hFF, 8'h00);
    check("rd_busy", {31'd0, busy}, 32'd1);
    xchk("rd_gap", 8'hFF, 8'hFF);
    xchk("rd_token", 8'hFF, 8'hFE);
    for (int i = 0; i < 512; i++) xchk("rd_data", 8'hFF, 8'(i));
    xchk("rd_crc0", 8'hFF, 8'hFF);
    xchk("rd_crc1", 8'hFF, 8'hFF);
    xchk("rd_end", 8'hFF, 8'hFF);
    check("rd_busy_clr", {31'd0, busy}, 32'd0);

    send_cmd(6'd17, 32'h0000_0004, 8'hFF);
    xchk("rd_range_r1", 8'hFF, 8'h40);
    xchk("rd_range_notoken", 8'hFF, 8'hFF);
    check("rd_range_busy", {31'd0, busy}, 32'd0);

    send_cmd(6'd24, 32'h0000_0001, 8'hFF);
    xchk("pw_r1", 8'hFF, 8'h00);
    xchk("pw_token", 8'hFE, 8'hFF);
    for (int i = 0; i < 100; i++) xchk("pw_data", 8'(i + 8'h80), 8'hFF);
    cs_set(1'b1);
    check("pw_abort_busy", {31'd0, busy}, 32'd0);
    check("pw_abort_miso", {31'd0, spi_if.spi_miso}, 32'd1);
    check("pw_abort_idle", {31'd0, in_idle}, 32'd0);

    cs_set(1'b0);
    send_cmd(6'd17, 32'h0000_0001, 8'hFF);
    xchk("pr_r1", 8'hFF, 8'h00);
    xchk("pr_gap", 8'hFF, 8'hFF);
    xchk("pr_token", 8'hFF, 8'hFE);
    for (int i = 0; i < 112; i++) xchk("pr_data", 8'hFF, (i < 100) ? 8'(i + 8'h80) : 8'(i));
    cs_set(1'b1);
    cs_set(1'b0);

    send_cmd(6'd13, 32'h0000_0000, 8'hFF);
    xchk("unsup_r1", 8'hFF, 8'h04);
    send_cmd(6'd0, 32'h0000_0000, 8'h95);
    xchk("cmd0_again_r1", 8'hFF, 8'h01);
    check("cmd0_again_idle", {31'd0, in_idle}, 32'd1);
    cs_set(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
